// File: rtl/raster_tri_scheduler.sv
`default_nettype none
// ============================================================================
// raster_tri_scheduler : round-robin triangle capture and MSB-first serializer
// feeding the rasterizer, with done handshake and watchdog.   Rev 1.0
// ============================================================================
module raster_tri_scheduler #(
  parameter int WORDS    = 9,
  parameter int WIDTH    = 16,
  parameter int WAIT_MAX = 65535
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             REQ0_WVALID,
  input  logic [WIDTH-1:0] REQ0_WDATA,
  output logic             REQ0_READY,
  input  logic             REQ1_WVALID,
  input  logic [WIDTH-1:0] REQ1_WDATA,
  output logic             REQ1_READY,
  output logic             SER_D,
  output logic             SER_VALID,
  input  logic             RAST_DONE,
  output logic             BUSY,
  output logic             GRANT,
  output logic [15:0]      TRI_COUNT,
  output logic             TIMEOUT_ERR
);

  localparam int SHW = WORDS * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOAD      = 2'd1,
    S_SEND      = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic [15:0]      wdog_q, wdog_d;
  logic [15:0]      tri_q, tri_d;
  logic             terr_q, terr_d;
  logic [SHW-1:0]   shift_q, shift_d;

  logic             ready0, ready1, accept;
  logic [WIDTH-1:0] wdata;

  // READY is decoded from registers only, so producers see no combinational
  // loop through their own WVALID.
  assign ready0 = (state_q == S_LOAD) && !grant_q;
  assign ready1 = (state_q == S_LOAD) &&  grant_q;
  assign accept = grant_q ? (REQ1_WVALID && ready1) : (REQ0_WVALID && ready0);
  assign wdata  = grant_q ? REQ1_WDATA : REQ0_WDATA;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wcnt_d  = wcnt_q;
    bcnt_d  = bcnt_q;
    wdog_d  = wdog_q;
    tri_d   = tri_q;
    terr_d  = terr_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        if (REQ0_WVALID || REQ1_WVALID) begin
          grant_d = (REQ0_WVALID && REQ1_WVALID) ? !grant_q : REQ1_WVALID;
          wcnt_d  = 4'd0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          // Shifting words in at the bottom leaves word 0 at the top once all
          // words have arrived.
          shift_d = {shift_q[SHW-WIDTH-1:0], wdata};
          if (wcnt_q == 4'(WORDS - 1)) begin
            wcnt_d  = 4'd0;
            bcnt_d  = 8'd0;
            state_d = S_SEND;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      S_SEND: begin
        shift_d = {shift_q[SHW-2:0], 1'b0};
        if (bcnt_q == 8'(SHW - 1)) begin
          bcnt_d  = 8'd0;
          wdog_d  = 16'd0;
          state_d = S_WAIT_DONE;
        end else begin
          bcnt_d = bcnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        // Done wins over a simultaneous watchdog expiry.
        if (RAST_DONE) begin
          tri_d   = tri_q + 16'd1;
          wdog_d  = 16'd0;
          state_d = S_IDLE;
        end else if (wdog_q == 16'(WAIT_MAX - 1)) begin
          terr_d  = 1'b1;
          wdog_d  = 16'd0;
          state_d = S_IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      grant_q <= 1'b1;
      wcnt_q  <= 4'd0;
      bcnt_q  <= 8'd0;
      wdog_q  <= 16'd0;
      tri_q   <= 16'd0;
      terr_q  <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      wcnt_q  <= wcnt_d;
      bcnt_q  <= bcnt_d;
      wdog_q  <= wdog_d;
      tri_q   <= tri_d;
      terr_q  <= terr_d;
      shift_q <= shift_d;
    end
  end

  assign REQ0_READY  = ready0;
  assign REQ1_READY  = ready1;
  assign SER_VALID   = (state_q == S_SEND);
  assign SER_D       = (state_q == S_SEND) && shift_q[SHW-1];
  assign BUSY        = (state_q != S_IDLE);
  assign GRANT       = grant_q;
  assign TRI_COUNT   = tri_q;
  assign TIMEOUT_ERR = terr_q;

endmodule
`default_nettype wire

// File: tb/tb_raster_tri_scheduler.sv
`default_nettype none
// Bench for raster_tri_scheduler: producer queues, serial capture and a
// word-level reference model of grants, bit stream, counters and watchdog.
module tb_raster_tri_scheduler;

  localparam int WAIT_MAX = 20;
  localparam int NB       = 144;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        REQ0_WVALID = 1'b0, REQ1_WVALID = 1'b0;
  logic [15:0] REQ0_WDATA = 16'd0, REQ1_WDATA = 16'd0;
  logic        REQ0_READY, REQ1_READY;
  logic        SER_D, SER_VALID, BUSY, GRANT, TIMEOUT_ERR;
  logic        RAST_DONE = 1'b0;
  logic [15:0] TRI_COUNT;

  raster_tri_scheduler #(.WORDS(9), .WIDTH(16), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .REQ0_WVALID(REQ0_WVALID), .REQ0_WDATA(REQ0_WDATA), .REQ0_READY(REQ0_READY),
    .REQ1_WVALID(REQ1_WVALID), .REQ1_WDATA(REQ1_WDATA), .REQ1_READY(REQ1_READY),
    .SER_D(SER_D), .SER_VALID(SER_VALID), .RAST_DONE(RAST_DONE),
    .BUSY(BUSY), .GRANT(GRANT), .TRI_COUNT(TRI_COUNT), .TIMEOUT_ERR(TIMEOUT_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;

  logic [15:0] q0[$], q1[$];
  logic        ser_bits[$], exp_bits[$], grant_log[$];
  logic [15:0] tw [36];
  int  cyc_n = 0, pend_cyc = 0;
  int  rdy0_cnt, rdy1_cnt, acc_cnt0, acc_cnt1, last_acc_cyc1;
  int  first_ser_cyc = -1, last_ser_cyc = -1;
  int  stall_at1 = -1, stall_left1 = 0;
  bit  pend0 = 0, pend1 = 0, busy_prev = 0, rr_viol = 0;
  int  exp_tri = 0;

  // Producer drivers and output monitor, all working #1 after the edge.
  always begin
    @(posedge CLK);
    cyc_n++;
    #1;
    if (pend0) begin void'(q0.pop_front()); acc_cnt0++; end
    if (pend1) begin void'(q1.pop_front()); acc_cnt1++; last_acc_cyc1 = pend_cyc; end
    if (SER_VALID) begin
      ser_bits.push_back(SER_D);
      if (first_ser_cyc < 0) first_ser_cyc = cyc_n;
      last_ser_cyc = cyc_n;
    end
    if (BUSY && !busy_prev) grant_log.push_back(GRANT);
    busy_prev = BUSY;
    if (REQ0_READY) rdy0_cnt++;
    if (REQ1_READY) rdy1_cnt++;
    if ((REQ1_READY && !GRANT) || (REQ0_READY && GRANT)) rr_viol = 1;
    REQ0_WVALID = (q0.size() > 0);
    REQ0_WDATA  = (q0.size() > 0) ? q0[0] : 16'd0;
    if (q1.size() > 0 && acc_cnt1 == stall_at1 && stall_left1 > 0) begin
      REQ1_WVALID = 1'b0;
      stall_left1--;
    end else begin
      REQ1_WVALID = (q1.size() > 0);
      REQ1_WDATA  = (q1.size() > 0) ? q1[0] : 16'd0;
    end
    pend0    = REQ0_WVALID && REQ0_READY;
    pend1    = REQ1_WVALID && REQ1_READY;
    pend_cyc = cyc_n;
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic wait_bits(input int n);
    for (int i = 0; i < 3000 && ser_bits.size() < n; i++) cyc();
  endtask

  task automatic clear_mon();
    ser_bits.delete(); exp_bits.delete(); grant_log.delete();
    rdy0_cnt = 0; rdy1_cnt = 0; acc_cnt0 = 0; acc_cnt1 = 0;
    first_ser_cyc = -1; last_ser_cyc = -1; rr_viol = 0;
  endtask

  task automatic gen_rand(input int ntri);
    for (int i = 0; i < ntri * 9; i++) tw[i] = 16'($urandom);
  endtask

  task automatic push_tri(input int p, input int base);
    for (int i = 0; i < 9; i++)
      if (p == 0) q0.push_back(tw[base + i]); else q1.push_back(tw[base + i]);
  endtask

  // Reference: word 0 first, each word MSB first.
  task automatic model_tri(input int base);
    for (int i = 0; i < 9; i++)
      for (int b = 15; b >= 0; b--) exp_bits.push_back(((tw[base + i] >> b) & 16'd1) != 0);
  endtask

  task automatic pulse_done();
    RAST_DONE = 1'b1;
    cyc();
    RAST_DONE = 1'b0;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    q0.delete(); q1.delete();
    RAST_DONE = 1'b0;
    cycles(2);
    RST_N = 1'b1;
    cyc();
    exp_tri = 0;
  endtask

  task automatic test_reset();
    RST_N = 1'b1;
    #1 RST_N = 1'b0;
    cycles(2);
    checks++;
    if ({REQ0_READY, REQ1_READY, SER_D, SER_VALID, BUSY, GRANT, TIMEOUT_ERR} !== 7'b0000010) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0000010",
               {REQ0_READY, REQ1_READY, SER_D, SER_VALID, BUSY, GRANT, TIMEOUT_ERR});
    end
    checks++;
    if (TRI_COUNT !== 16'd0) begin errors++; $display("FAIL reset_tri_count got %0d exp 0", TRI_COUNT); end
    RST_N = 1'b1;
    cycles(3);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_without_request busy got %b exp 0", BUSY); end
  endtask

  task automatic test_single();
    int bad = 0;
    logic [15:0] head;
    clear_mon();
    tw[0:8] = '{16'h0040, 16'h0080, 16'hFFFF, 16'h0100, 16'h0080, 16'hFFFF, 16'h00C0, 16'h0140, 16'hFFFF};
    push_tri(0, 0);
    model_tri(0);
    wait_bits(NB);
    cyc();
    checks++;
    if (rdy0_cnt != 9) begin errors++; $display("FAIL single_ready0_cycles got %0d exp 9", rdy0_cnt); end
    for (int i = 0; i < NB && i < ser_bits.size(); i++) if (ser_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (ser_bits.size() != NB || bad != 0) begin
      errors++; $display("FAIL single_bits got %0d bits with %0d wrong exp %0d bits", ser_bits.size(), bad, NB);
    end
    head = 16'd0;
    for (int i = 0; i < 16 && i < ser_bits.size(); i++) head = {head[14:0], ser_bits[i]};
    checks++;
    if (head !== 16'h0040) begin errors++; $display("FAIL single_first_word got %h exp 0040", head); end
    checks++;
    if (last_ser_cyc - first_ser_cyc + 1 != NB) begin
      errors++; $display("FAIL single_ser_span got %0d exp %0d", last_ser_cyc - first_ser_cyc + 1, NB);
    end
    checks++;
    if ({BUSY, SER_VALID} !== 2'b10) begin errors++; $display("FAIL single_wait_state busy,valid got %b exp 10", {BUSY, SER_VALID}); end
    pulse_done();
    exp_tri++;
    checks++;
    if (TRI_COUNT !== 16'(exp_tri) || BUSY !== 1'b0) begin
      errors++; $display("FAIL single_done tri_count=%0d busy=%b exp %0d,0", TRI_COUNT, BUSY, exp_tri);
    end
  endtask

  task automatic test_round_robin();
    int bad = 0, n0 = 2, n1 = 2, i0 = 0, i1 = 0;
    logic last = 1'b1, g;
    logic exp_g[$];
    do_reset();
    clear_mon();
    gen_rand(4);
    push_tri(0, 0); push_tri(0, 18);
    push_tri(1, 9); push_tri(1, 27);
    for (int k = 0; k < 4; k++) begin
      g = (n0 > 0 && n1 > 0) ? !last : (n1 > 0);
      exp_g.push_back(g);
      if (g) begin model_tri(9 + 18 * i1); i1++; n1--; end
      else   begin model_tri(18 * i0);     i0++; n0--; end
      last = g;
    end
    for (int k = 0; k < 4; k++) begin
      wait_bits(NB * (k + 1));
      cyc();
      cycles(10);
      pulse_done();
      exp_tri++;
    end
    bad = 0;
    for (int k = 0; k < 4 && k < grant_log.size(); k++) if (grant_log[k] !== exp_g[k]) bad++;
    checks++;
    if (grant_log.size() != 4 || bad != 0) begin
      errors++; $display("FAIL rr_grants got %0d grants %0d wrong exp 0,1,0,1", grant_log.size(), bad);
    end
    checks++;
    if (rr_viol) begin errors++; $display("FAIL rr_ready_vs_grant got ready for non-granted producer exp none"); end
    checks++;
    if (TRI_COUNT !== 16'(exp_tri)) begin errors++; $display("FAIL rr_tri_count got %0d exp %0d", TRI_COUNT, exp_tri); end
    bad = 0;
    for (int i = 0; i < exp_bits.size() && i < ser_bits.size(); i++) if (ser_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (ser_bits.size() != exp_bits.size() || bad != 0) begin
      errors++; $display("FAIL rr_bits got %0d bits with %0d wrong exp %0d", ser_bits.size(), bad, exp_bits.size());
    end
  endtask

  task automatic test_stalled_load();
    int bad = 0;
    clear_mon();
    gen_rand(1);
    stall_at1 = 5; stall_left1 = 3;
    push_tri(1, 0);
    model_tri(0);
    for (int i = 0; i < 200 && acc_cnt1 < 5; i++) cyc();
    cycles(2);
    checks++;
    if (dut.wcnt_q !== 4'd5 || REQ1_READY !== 1'b1 || SER_VALID !== 1'b0) begin
      errors++; $display("FAIL stall_hold wcnt=%0d ready1=%b valid=%b exp 5,1,0", dut.wcnt_q, REQ1_READY, SER_VALID);
    end
    wait_bits(NB);
    checks++;
    if (first_ser_cyc != last_acc_cyc1 + 1) begin
      errors++; $display("FAIL stall_send_latency got %0d exp %0d", first_ser_cyc - last_acc_cyc1, 1);
    end
    checks++;
    if (rdy1_cnt != 12) begin errors++; $display("FAIL stall_ready1_cycles got %0d exp 12", rdy1_cnt); end
    for (int i = 0; i < NB && i < ser_bits.size(); i++) if (ser_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (ser_bits.size() != NB || bad != 0) begin
      errors++; $display("FAIL stall_bits got %0d bits with %0d wrong exp %0d", ser_bits.size(), bad, NB);
    end
    stall_at1 = -1;
    cyc();
    pulse_done();
    exp_tri++;
    checks++;
    if (TRI_COUNT !== 16'(exp_tri)) begin errors++; $display("FAIL stall_tri_count got %0d exp %0d", TRI_COUNT, exp_tri); end
  endtask

  task automatic test_done_at_expiry();
    clear_mon();
    gen_rand(1);
    push_tri(0, 0);
    wait_bits(NB);
    cyc();
    cycles(WAIT_MAX - 1);
    checks++;
    if (BUSY !== 1'b1) begin errors++; $display("FAIL expiry_still_waiting busy got %b exp 1", BUSY); end
    RAST_DONE = 1'b1;
    cyc();
    RAST_DONE = 1'b0;
    exp_tri++;
    checks++;
    if (TRI_COUNT !== 16'(exp_tri) || TIMEOUT_ERR !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL expiry_done tri=%0d err=%b busy=%b exp %0d,0,0", TRI_COUNT, TIMEOUT_ERR, BUSY, exp_tri);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    clear_mon();
    gen_rand(2);
    push_tri(1, 0);
    wait_bits(50);
    pulse_done();
    checks++;
    if (TRI_COUNT !== 16'(exp_tri)) begin errors++; $display("FAIL spurious_done tri got %0d exp %0d", TRI_COUNT, exp_tri); end
    wait_bits(NB);
    cyc();
    cycles(WAIT_MAX - 1);
    checks++;
    if (TIMEOUT_ERR !== 1'b0 || BUSY !== 1'b1) begin
      errors++; $display("FAIL timeout_early err=%b busy=%b exp 0,1", TIMEOUT_ERR, BUSY);
    end
    cyc();
    checks++;
    if (TIMEOUT_ERR !== 1'b1 || BUSY !== 1'b0 || TRI_COUNT !== 16'(exp_tri)) begin
      errors++; $display("FAIL timeout_expiry err=%b busy=%b tri=%0d exp 1,0,%0d", TIMEOUT_ERR, BUSY, TRI_COUNT, exp_tri);
    end
    clear_mon();
    push_tri(0, 9);
    model_tri(9);
    wait_bits(NB);
    cyc();
    pulse_done();
    exp_tri++;
    for (int i = 0; i < NB && i < ser_bits.size(); i++) if (ser_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (ser_bits.size() != NB || bad != 0) begin
      errors++; $display("FAIL after_timeout_bits got %0d bits with %0d wrong exp %0d", ser_bits.size(), bad, NB);
    end
    checks++;
    if (TRI_COUNT !== 16'(exp_tri) || TIMEOUT_ERR !== 1'b1) begin
      errors++; $display("FAIL after_timeout_state tri=%0d err=%b exp %0d,1", TRI_COUNT, TIMEOUT_ERR, exp_tri);
    end
  endtask

  task automatic test_reset_mid_send();
    int bad = 0;
    clear_mon();
    gen_rand(3);
    push_tri(1, 0);
    wait_bits(70);
    RST_N = 1'b0;
    #1;
    checks++;
    if ({SER_VALID, BUSY, GRANT, TIMEOUT_ERR} !== 4'b0010 || TRI_COUNT !== 16'd0) begin
      errors++; $display("FAIL midsend_reset valid,busy,grant,err=%b tri=%0d exp 0010,0",
                         {SER_VALID, BUSY, GRANT, TIMEOUT_ERR}, TRI_COUNT);
    end
    q0.delete(); q1.delete();
    cycles(2);
    clear_mon();
    exp_tri = 0;
    RST_N = 1'b1;
    cyc();
    push_tri(0, 9);
    push_tri(1, 18);
    model_tri(9);
    wait_bits(NB);
    cycles(3);
    checks++;
    if (grant_log.size() < 1 || grant_log[0] !== 1'b0) begin
      errors++; $display("FAIL midsend_first_grant got %0d entries exp producer 0", grant_log.size());
    end
    for (int i = 0; i < NB && i < ser_bits.size(); i++) if (ser_bits[i] !== exp_bits[i]) bad++;
    checks++;
    if (ser_bits.size() != NB || bad != 0) begin
      errors++; $display("FAIL midsend_new_bits got %0d bits with %0d wrong exp %0d", ser_bits.size(), bad, NB);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stalled_load();
    test_done_at_expiry();
    test_timeout();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached time limit exp completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
